game_ctrl: RTL and testbench

//  Central game-state sequencer sitting upstream of the jump, ground, cactus and score stages.

---
 rtl/game_ctrl_pkg.sv | 23 ++
 rtl/game_ctrl_if.sv | 35 +++
 rtl/game_ctrl_btn_debounce.sv | 51 +++++
 rtl/game_ctrl.sv | 134 +++++++++++++
 tb/tb_game_ctrl.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_ctrl_pkg.sv
// Shared types and constants for the game-state sequencer.
//   game_state_t : IDLE / ARMED / RUNNING / OVER / PAUSED
//   HIT_W        : width of the per-frame overlap counter
//   HOLD_W       : width of the game-over hold counter
//   sat_inc()    : saturating increment for HIT_W-wide counters
package game_ctrl_pkg;

    localparam int unsigned HIT_W  = 8;
    localparam int unsigned HOLD_W = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        RUNNING = 3'd2,
        OVER    = 3'd3,
        PAUSED  = 3'd4
    } game_state_t;

    function automatic logic [HIT_W-1:0] sat_inc(input logic [HIT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// Signal bundle between the game sequencer and its surroundings.
//   START_N, JUMP_N : raw active-low buttons (asynchronous)
//   vs              : VGA vertical sync, low during the blanking pulse
//   px_dinosaur     : dinosaur pixel lit at the current scan position
//   px_cactus       : cactus pixel lit at the current scan position
//   game_status     : 1 = game running
//   game_over       : 1 while in OVER
//   start_pulse     : one-cycle debounced START press
//   jump_pulse      : one-cycle debounced JUMP press, gated by game_status
//   frame_tick      : one-cycle pulse on each synchronised vs falling edge
// master drives the raw inputs; slave is the sequencer.
interface game_ctrl_if;

    logic START_N;
    logic JUMP_N;
    logic vs;
    logic px_dinosaur;
    logic px_cactus;
    logic game_status;
    logic game_over;
    logic start_pulse;
    logic jump_pulse;
    logic frame_tick;

    modport master (
        output START_N, JUMP_N, vs, px_dinosaur, px_cactus,
        input  game_status, game_over, start_pulse, jump_pulse, frame_tick
    );

    modport slave (
        input  START_N, JUMP_N, vs, px_dinosaur, px_cactus,
        output game_status, game_over, start_pulse, jump_pulse, frame_tick
    );

endinterface

// File: rtl/game_ctrl_btn_debounce.sv
// Button debouncer: 2-flop synchroniser, stability counter and press-edge pulse.
// The stable value starts as "released" (1) and only follows the synchronised input
// once it has differed from it for 2**DB_BITS consecutive cycles.
//   CLK     : system clock
//   RESET_N : asynchronous active-low reset
//   in_n    : raw active-low button
//   press   : one-cycle pulse on each stable 1->0 transition
module game_ctrl_btn_debounce #(
    parameter int unsigned DB_BITS = 16
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic in_n,
    output logic press
);

    logic               sync1_q;
    logic               sync2_q;
    logic               stable_q;
    logic               stable_prev_q;
    logic               press_q;
    logic [DB_BITS-1:0] cnt_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            stable_q      <= 1'b1;
            stable_prev_q <= 1'b1;
            press_q       <= 1'b0;
            cnt_q         <= '0;
        end else begin
            sync1_q       <= in_n;
            sync2_q       <= sync1_q;
            stable_prev_q <= stable_q;
            // Only a falling stable value is a press; releases are silent.
            press_q       <= stable_prev_q & ~stable_q;
            if (sync2_q == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == '1) begin
                cnt_q    <= '0;
                stable_q <= sync2_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign press = press_q;

endmodule

// File: rtl/game_ctrl.sv
// Central game-state sequencer feeding the jump, ground, cactus and score stages.
// Debounces START/JUMP, detects frame boundaries on vs, counts dinosaur/cactus overlap
// pixels per frame and runs the IDLE/ARMED/RUNNING/OVER game FSM.
// Optional build macro GAME_CTRL_PAUSE_EN adds a PAUSED state entered/left with START.
//   CLK     : system clock
//   RESET_N : asynchronous active-low reset
//   bus     : game_ctrl_if.slave (raw inputs in, status/pulses out)
// Parameters: DB_BITS (debounce width), MIN_HITS (overlaps per frame to collide),
//             HOLD_FRAMES (frames in OVER before START is accepted).
module game_ctrl #(
    parameter int unsigned DB_BITS     = 16,
    parameter int unsigned MIN_HITS    = 2,
    parameter int unsigned HOLD_FRAMES = 30
) (
    input  logic        CLK,
    input  logic        RESET_N,
    game_ctrl_if.slave  bus
);

    import game_ctrl_pkg::*;

    localparam logic [HIT_W-1:0]  MinHits = MIN_HITS[HIT_W-1:0];
    localparam logic [HOLD_W-1:0] HoldMax = HOLD_FRAMES[HOLD_W-1:0];

    logic start_press;
    logic jump_press;

    game_ctrl_btn_debounce #(.DB_BITS(DB_BITS)) u_start_db (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .in_n    (bus.START_N),
        .press   (start_press)
    );

    game_ctrl_btn_debounce #(.DB_BITS(DB_BITS)) u_jump_db (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .in_n    (bus.JUMP_N),
        .press   (jump_press)
    );

    // vs synchroniser plus one delay stage for edge detection. Reset low so that
    // vs rising out of reset never looks like a falling edge.
    logic vs_s1_q, vs_s2_q, vs_s3_q;
    logic frame_tick;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            vs_s1_q <= 1'b0;
            vs_s2_q <= 1'b0;
            vs_s3_q <= 1'b0;
        end else begin
            vs_s1_q <= bus.vs;
            vs_s2_q <= vs_s1_q;
            vs_s3_q <= vs_s2_q;
        end
    end

    assign frame_tick = vs_s3_q & ~vs_s2_q;

    game_state_t       state_q, state_d;
    logic [HIT_W-1:0]  hits_q, hits_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              game_status_q;
    logic              game_over_q;

    always_comb begin
        state_d = state_q;
        hits_d  = hits_q;
        hold_d  = hold_q;

        // Clear on the frame boundary wins over a same-cycle overlap.
        if (frame_tick) begin
            hits_d = '0;
        end else if (state_q == RUNNING && bus.px_dinosaur && bus.px_cactus) begin
            hits_d = sat_inc(hits_q);
        end

        case (state_q)
            IDLE: begin
                if (start_press) state_d = ARMED;
            end
            ARMED: begin
                if (frame_tick) state_d = RUNNING;
            end
            RUNNING: begin
                // hits_q still holds the finished frame's count on the tick cycle.
                if (frame_tick && hits_q >= MinHits) begin
                    state_d = OVER;
                    hold_d  = '0;
                end
`ifdef GAME_CTRL_PAUSE_EN
                else if (start_press) begin
                    state_d = PAUSED;
                end
`endif
            end
            OVER: begin
                if (frame_tick && hold_q != HoldMax) hold_d = hold_q + 1'b1;
                // Early presses are simply dropped.
                if (start_press && hold_q == HoldMax) state_d = ARMED;
            end
`ifdef GAME_CTRL_PAUSE_EN
            PAUSED: begin
                if (start_press) state_d = ARMED;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q       <= IDLE;
            hits_q        <= '0;
            hold_q        <= '0;
            game_status_q <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            hits_q        <= hits_d;
            hold_q        <= hold_d;
            game_status_q <= (state_d == RUNNING);
            game_over_q   <= (state_d == OVER);
        end
    end

    assign bus.game_status = game_status_q;
    assign bus.game_over   = game_over_q;
    assign bus.start_pulse = start_press;
    assign bus.jump_pulse  = jump_press & game_status_q;
    assign bus.frame_tick  = frame_tick;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with DB_BITS = 3, MIN_HITS = 2, HOLD_FRAMES = 3.
module tb_game_ctrl;

    import game_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    game_ctrl_if bus();

    game_ctrl #(
        .DB_BITS     (3),
        .MIN_HITS    (2),
        .HOLD_FRAMES (3)
    ) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds one button low for 12 cycles, then high for 14; records pulses by cycle.
    task automatic press_btn(input bit is_jump, output int n_start, output int first_start,
                             output int n_jump, output int first_jump, output int gs_low);
        n_start = 0; first_start = -1; n_jump = 0; first_jump = -1; gs_low = 0;
        if (is_jump) bus.JUMP_N = 1'b0;
        else         bus.START_N = 1'b0;
        for (int k = 1; k <= 26; k++) begin
            if (k == 13) begin
                bus.START_N = 1'b1;
                bus.JUMP_N  = 1'b1;
            end
            tick();
            if (bus.start_pulse) begin
                n_start++;
                if (first_start < 0) first_start = k;
            end
            if (bus.jump_pulse) begin
                n_jump++;
                if (first_jump < 0) first_jump = k;
            end
            if (!bus.game_status) gs_low++;
        end
    endtask

    // One frame: `hits` isolated overlap pixels, two non-overlapping pixels, then a vs pulse.
    // ft2/gs2 sampled on the frame_tick cycle, ft3/gs3 one cycle later.
    task automatic run_frame(input int hits, input bit px_on_tick,
                             output bit ft2, output bit ft3, output bit gs2, output bit gs3);
        for (int i = 0; i < hits; i++) begin
            bus.px_dinosaur = 1'b1; bus.px_cactus = 1'b1;
            tick();
            bus.px_dinosaur = 1'b0; bus.px_cactus = 1'b0;
            tick();
        end
        bus.px_dinosaur = 1'b1;
        tick();
        bus.px_dinosaur = 1'b0; bus.px_cactus = 1'b1;
        tick();
        bus.px_cactus = 1'b0;
        bus.vs = 1'b0;
        tick();
        tick();
        ft2 = bus.frame_tick; gs2 = bus.game_status;
        if (px_on_tick) begin
            bus.px_dinosaur = 1'b1; bus.px_cactus = 1'b1;
        end
        tick();
        ft3 = bus.frame_tick; gs3 = bus.game_status;
        bus.px_dinosaur = 1'b0; bus.px_cactus = 1'b0;
        tick();
        bus.vs = 1'b1;
        tick(); tick(); tick();
    endtask

    task automatic test_reset();
        int ft_seen;
        rst_n = 1'b0;
        bus.START_N = 1'b1; bus.JUMP_N = 1'b1; bus.vs = 1'b1;
        bus.px_dinosaur = 1'b0; bus.px_cactus = 1'b0;
        tick(); tick(); tick();
        checks++; if (bus.game_status !== 1'b0) begin errors++;
            $display("FAIL reset_game_status: got %b expected 0", bus.game_status); end
        checks++; if (bus.game_over !== 1'b0) begin errors++;
            $display("FAIL reset_game_over: got %b expected 0", bus.game_over); end
        checks++; if (bus.start_pulse !== 1'b0 || bus.jump_pulse !== 1'b0) begin errors++;
            $display("FAIL reset_pulses: got start=%b jump=%b expected 0 0",
                     bus.start_pulse, bus.jump_pulse); end
        checks++; if (dut.state_q !== IDLE) begin errors++;
            $display("FAIL reset_state: got %0d expected %0d", dut.state_q, IDLE); end
        rst_n = 1'b1;
        ft_seen = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (bus.frame_tick) ft_seen++;
        end
        checks++; if (ft_seen != 0) begin errors++;
            $display("FAIL reset_no_frame_tick: got %0d ticks expected 0", ft_seen); end
    endtask

    task automatic test_debounce();
        int glitch_pulses, ns, fs, nj, fj, gl;
        glitch_pulses = 0;
        bus.START_N = 1'b0;
        for (int k = 0; k < 3; k++) begin tick(); if (bus.start_pulse) glitch_pulses++; end
        bus.START_N = 1'b1;
        for (int k = 0; k < 2; k++) begin tick(); if (bus.start_pulse) glitch_pulses++; end
        press_btn(1'b0, ns, fs, nj, fj, gl);
        checks++; if (glitch_pulses != 0) begin errors++;
            $display("FAIL debounce_glitch: got %0d pulses expected 0", glitch_pulses); end
        checks++; if (ns != 1) begin errors++;
            $display("FAIL debounce_pulse_count: got %0d expected 1", ns); end
        checks++; if (fs != 11) begin errors++;
            $display("FAIL debounce_latency: got cycle %0d expected 11", fs); end
        checks++; if (nj != 0) begin errors++;
            $display("FAIL debounce_no_jump: got %0d expected 0", nj); end
        checks++; if (dut.state_q !== ARMED) begin errors++;
            $display("FAIL idle_to_armed: got %0d expected %0d", dut.state_q, ARMED); end
    endtask

    task automatic test_jump_gated();
        int ns, fs, nj, fj, gl;
        press_btn(1'b1, ns, fs, nj, fj, gl);
        checks++; if (nj != 0) begin errors++;
            $display("FAIL jump_gated_armed: got %0d pulses expected 0", nj); end
        checks++; if (ns != 0) begin errors++;
            $display("FAIL jump_no_start: got %0d start pulses expected 0", ns); end
    endtask

    task automatic test_frame_start();
        bit ft2, ft3, gs2, gs3;
        run_frame(0, 1'b0, ft2, ft3, gs2, gs3);
        checks++; if (ft2 !== 1'b1) begin errors++;
            $display("FAIL frame_tick_assert: got %b expected 1", ft2); end
        checks++; if (ft3 !== 1'b0) begin errors++;
            $display("FAIL frame_tick_width: got %b expected 0", ft3); end
        checks++; if (gs2 !== 1'b0) begin errors++;
            $display("FAIL run_not_early: got %b expected 0", gs2); end
        checks++; if (gs3 !== 1'b1) begin errors++;
            $display("FAIL run_after_tick: got %b expected 1", gs3); end
    endtask

    task automatic test_jump_running();
        int ns, fs, nj, fj, gl;
        press_btn(1'b1, ns, fs, nj, fj, gl);
        checks++; if (nj != 1) begin errors++;
            $display("FAIL jump_running_count: got %0d expected 1", nj); end
        checks++; if (fj != 11) begin errors++;
            $display("FAIL jump_running_latency: got cycle %0d expected 11", fj); end
        checks++; if (gl != 0) begin errors++;
            $display("FAIL jump_running_status: got %0d low cycles expected 0", gl); end
    endtask

    task automatic test_collision();
        bit ft2, ft3, gs2, gs3;
        run_frame(1, 1'b0, ft2, ft3, gs2, gs3);
        checks++; if (gs3 !== 1'b1 || bus.game_over !== 1'b0) begin errors++;
            $display("FAIL one_hit_stays: got status=%b over=%b expected 1 0",
                     gs3, bus.game_over); end
        // Overlap on the tick cycle must not carry into the next frame.
        run_frame(1, 1'b1, ft2, ft3, gs2, gs3);
        checks++; if (gs3 !== 1'b1) begin errors++;
            $display("FAIL tick_overlap_frame: got %b expected 1", gs3); end
        run_frame(1, 1'b0, ft2, ft3, gs2, gs3);
        checks++; if (gs3 !== 1'b1) begin errors++;
            $display("FAIL clear_wins: got %b expected 1", gs3); end
        run_frame(2, 1'b0, ft2, ft3, gs2, gs3);
        checks++; if (gs2 !== 1'b1 || gs3 !== 1'b0) begin errors++;
            $display("FAIL two_hits_status: got %b%b expected 10", gs2, gs3); end
        checks++; if (bus.game_over !== 1'b1) begin errors++;
            $display("FAIL two_hits_over: got %b expected 1", bus.game_over); end
    endtask

    task automatic test_over_hold();
        bit ft2, ft3, gs2, gs3;
        int ns, fs, nj, fj, gl;
        run_frame(0, 1'b0, ft2, ft3, gs2, gs3);
        press_btn(1'b0, ns, fs, nj, fj, gl);
        checks++; if (ns != 1) begin errors++;
            $display("FAIL over_start_seen: got %0d expected 1", ns); end
        checks++; if (bus.game_over !== 1'b1) begin errors++;
            $display("FAIL over_early_start: got %b expected 1", bus.game_over); end
        checks++; if (nj != 0) begin errors++;
            $display("FAIL over_no_jump: got %0d expected 0", nj); end
        run_frame(0, 1'b0, ft2, ft3, gs2, gs3);
        run_frame(0, 1'b0, ft2, ft3, gs2, gs3);
        checks++; if (bus.game_over !== 1'b1) begin errors++;
            $display("FAIL over_not_queued: got %b expected 1", bus.game_over); end
        press_btn(1'b0, ns, fs, nj, fj, gl);
        checks++; if (bus.game_over !== 1'b0 || bus.game_status !== 1'b0) begin errors++;
            $display("FAIL over_to_armed: got over=%b status=%b expected 0 0",
                     bus.game_over, bus.game_status); end
        checks++; if (dut.state_q !== ARMED) begin errors++;
            $display("FAIL over_to_armed_state: got %0d expected %0d", dut.state_q, ARMED); end
        run_frame(0, 1'b0, ft2, ft3, gs2, gs3);
        checks++; if (gs2 !== 1'b0 || gs3 !== 1'b1) begin errors++;
            $display("FAIL rearm_run: got %b%b expected 01", gs2, gs3); end
    endtask

    task automatic test_pause();
        bit ft2, ft3, gs2, gs3;
        int ns, fs, nj, fj, gl;
        press_btn(1'b0, ns, fs, nj, fj, gl);
`ifdef GAME_CTRL_PAUSE_EN
        checks++; if (bus.game_status !== 1'b0 || bus.game_over !== 1'b0) begin errors++;
            $display("FAIL pause_enter: got status=%b over=%b expected 0 0",
                     bus.game_status, bus.game_over); end
        run_frame(2, 1'b0, ft2, ft3, gs2, gs3);
        checks++; if (bus.game_status !== 1'b0 || bus.game_over !== 1'b0) begin errors++;
            $display("FAIL pause_hold: got status=%b over=%b expected 0 0",
                     bus.game_status, bus.game_over); end
        press_btn(1'b0, ns, fs, nj, fj, gl);
        checks++; if (bus.game_status !== 1'b0) begin errors++;
            $display("FAIL pause_rearm: got %b expected 0", bus.game_status); end
        run_frame(0, 1'b0, ft2, ft3, gs2, gs3);
        checks++; if (gs2 !== 1'b0 || gs3 !== 1'b1) begin errors++;
            $display("FAIL pause_resume: got %b%b expected 01", gs2, gs3); end
`else
        checks++; if (gl != 0 || bus.game_status !== 1'b1) begin errors++;
            $display("FAIL nopause_first: got %0d low cycles status=%b expected 0 1",
                     gl, bus.game_status); end
        press_btn(1'b0, ns, fs, nj, fj, gl);
        checks++; if (gl != 0) begin errors++;
            $display("FAIL nopause_second: got %0d low cycles expected 0", gl); end
        run_frame(0, 1'b0, ft2, ft3, gs2, gs3);
        checks++; if (gs2 !== 1'b1 || gs3 !== 1'b1) begin errors++;
            $display("FAIL nopause_frame: got %b%b expected 11", gs2, gs3); end
`endif
    endtask

    task automatic test_reset_mid_game();
        checks++; if (bus.game_status !== 1'b1) begin errors++;
            $display("FAIL mid_reset_precond: got %b expected 1", bus.game_status); end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.game_status !== 1'b0 || bus.game_over !== 1'b0) begin errors++;
            $display("FAIL mid_reset_outputs: got status=%b over=%b expected 0 0",
                     bus.game_status, bus.game_over); end
        checks++; if (dut.state_q !== IDLE) begin errors++;
            $display("FAIL mid_reset_state: got %0d expected %0d", dut.state_q, IDLE); end
        tick();
        rst_n = 1'b1;
        tick(); tick();
        checks++; if (dut.state_q !== IDLE || bus.game_status !== 1'b0) begin errors++;
            $display("FAIL post_reset_idle: got state=%0d status=%b expected %0d 0",
                     dut.state_q, bus.game_status, IDLE); end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_jump_gated();
        test_frame_start();
        test_jump_running();
        test_collision();
        test_over_hold();
        test_pause();
        test_reset_mid_game();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
